// File: rtl/fifo_flex_pkg.sv
// ----------------------------------------------------------------------------
// fifo_flex_pkg
// Shared constants and width helpers for the flexible 1R1W synchronous FIFO.
// The package cannot carry the FIFO's parameters, so the in-module pointer and
// count types are derived from the helpers below via $clog2.
// ----------------------------------------------------------------------------
package fifo_flex_pkg;

    // Default geometry used when the top is instantiated without overrides.
    localparam int WIDTH_D = 32;
    localparam int DEPTH_D = 12;

    // Bits needed to index 0..depth-1. Depth is at least 2, but keep a floor
    // of one bit so the helper is safe for any caller.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Bits needed to represent an occupancy of 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Default-geometry type helpers for code that does not override sizes.
    typedef logic [$clog2(DEPTH_D + 1)-1:0] count_t;
    typedef logic [$clog2(DEPTH_D)-1:0]     ptr_t;

endpackage : fifo_flex_pkg

// File: rtl/fifo_sync_1r1w_flex_mem.sv
// ----------------------------------------------------------------------------
// fifo_mem_1r1w
// DEPTH_P x WIDTH_P register array backing the FIFO. No reset: contents are
// only meaningful once written, and the control logic tracks validity.
//
// Ports:
//   clk_i      - clock
//   w_v_i      - write enable
//   w_addr_i   - write address (0..DEPTH_P-1)
//   w_data_i   - write data
//   r_addr_i   - read address (0..DEPTH_P-1)
//   r_data_o   - combinational read data
// ----------------------------------------------------------------------------
module fifo_mem_1r1w
    import fifo_flex_pkg::*;
#(
    parameter int WIDTH_P = WIDTH_D,
    parameter int DEPTH_P = DEPTH_D
) (
    input  logic                        clk_i,
    input  logic                        w_v_i,
    input  logic [ptr_w(DEPTH_P)-1:0]   w_addr_i,
    input  logic [WIDTH_P-1:0]          w_data_i,
    input  logic [ptr_w(DEPTH_P)-1:0]   r_addr_i,
    output logic [WIDTH_P-1:0]          r_data_o
);

    logic [WIDTH_P-1:0] mem_q [DEPTH_P];

    always_ff @(posedge clk_i) begin
        if (w_v_i) begin
            mem_q[w_addr_i] <= w_data_i;
        end
    end

    // Addresses are always kept below DEPTH_P by the control logic.
    assign r_data_o = mem_q[r_addr_i];

endmodule : fifo_mem_1r1w

// File: rtl/fifo_sync_1r1w_flex.sv
// ----------------------------------------------------------------------------
// fifo_sync_1r1w_flex
// Single-clock FIFO with arbitrary depth/width, occupancy count, programmable
// almost-full/almost-empty flags, synchronous flush and a sticky error flag.
// The head entry is held in a registered output buffer.
//
// Handshakes:
//   Input side is valid/ready: a word is accepted on a rising edge where
//   valid_i & ready_o. Output side is valid/yumi: the head is consumed on a
//   rising edge where yumi_i & valid_o. ready_o and valid_o come only from
//   registered state, so yumi_i may be derived combinationally from valid_o.
//
// Ports:
//   clk_i          - clock, rising edge
//   reset_n_i      - asynchronous active-low reset
//   flush_i        - synchronous flush, dominates enqueue/dequeue
//   data_i/valid_i - enqueue data / request
//   ready_o        - not full
//   valid_o/data_o - head present / head word (from output buffer)
//   yumi_i         - consumer takes head
//   count_o        - occupancy 0..DEPTH_P
//   almost_full_o  - count_o >= AFULL_P
//   almost_empty_o - count_o <= AEMPTY_P
//   err_o          - sticky, set by yumi_i while empty; cleared by flush/reset
// ----------------------------------------------------------------------------
module fifo_sync_1r1w_flex
    import fifo_flex_pkg::*;
#(
    parameter int WIDTH_P  = WIDTH_D,
    parameter int DEPTH_P  = DEPTH_D,
    parameter int AFULL_P  = DEPTH_P - 2,
    parameter int AEMPTY_P = 2
) (
    input  logic                            clk_i,
    input  logic                            reset_n_i,
    input  logic                            flush_i,
    input  logic [WIDTH_P-1:0]              data_i,
    input  logic                            valid_i,
    output logic                            ready_o,
    output logic                            valid_o,
    output logic [WIDTH_P-1:0]              data_o,
    input  logic                            yumi_i,
    output logic [$clog2(DEPTH_P+1)-1:0]    count_o,
    output logic                            almost_full_o,
    output logic                            almost_empty_o,
    output logic                            err_o
);

    localparam int PTR_W = ptr_w(DEPTH_P);
    localparam int CNT_W = cnt_w(DEPTH_P);

    if (DEPTH_P < 2 || AFULL_P > DEPTH_P || AEMPTY_P >= DEPTH_P) begin : g_param_err
        $fatal(1, "fifo_sync_1r1w_flex: illegal DEPTH_P/AFULL_P/AEMPTY_P combination");
    end

    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               err_q, err_d;
    logic [WIDTH_P-1:0] buf_q, buf_d;

    logic               full, empty, enq, deq;
    logic [PTR_W-1:0]   rd_ptr_inc, wr_ptr_inc;
    logic [WIDTH_P-1:0] mem_rdata;
    logic               mem_we;

    assign full  = (count_q == CNT_W'(DEPTH_P));
    assign empty = (count_q == '0);

    assign ready_o = ~full;
    assign valid_o = ~empty;

    assign enq = valid_i & ready_o;
    assign deq = yumi_i & valid_o;

    // Explicit wrap so non-power-of-two depths never index past the array.
    assign rd_ptr_inc = (rd_ptr_q == PTR_W'(DEPTH_P - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    assign wr_ptr_inc = (wr_ptr_q == PTR_W'(DEPTH_P - 1)) ? '0 : wr_ptr_q + PTR_W'(1);

    // A flush drops the enqueue in its cycle, so the write is suppressed too.
    assign mem_we = enq & ~flush_i;

    fifo_mem_1r1w #(
        .WIDTH_P (WIDTH_P),
        .DEPTH_P (DEPTH_P)
    ) u_mem (
        .clk_i    (clk_i),
        .w_v_i    (mem_we),
        .w_addr_i (wr_ptr_q),
        .w_data_i (data_i),
        .r_addr_i (rd_ptr_inc),
        .r_data_o (mem_rdata)
    );

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        err_d    = err_q;
        buf_d    = buf_q;

        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            err_d    = 1'b0;
        end else begin
            if (yumi_i && empty) begin
                err_d = 1'b1;
            end
            if (enq) begin
                wr_ptr_d = wr_ptr_inc;
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_inc;
            end

            // The buffer always mirrors mem[rd_ptr]; refill it from the entry
            // behind the head, or from data_i when that entry is still in flight.
            unique case ({enq, deq})
                2'b10: begin
                    count_d = count_q + CNT_W'(1);
                    if (empty) begin
                        buf_d = data_i;
                    end
                end
                2'b01: begin
                    count_d = count_q - CNT_W'(1);
                    buf_d   = mem_rdata;
                end
                2'b11: begin
                    buf_d = (count_q == CNT_W'(1)) ? data_i : mem_rdata;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    // Data-path register: contents are only observed while valid_o is high.
    always_ff @(posedge clk_i) begin
        buf_q <= buf_d;
    end

    assign data_o         = buf_q;
    assign count_o        = count_q;
    assign err_o          = err_q;
    assign almost_full_o  = (count_q >= CNT_W'(AFULL_P));
    assign almost_empty_o = (count_q <= CNT_W'(AEMPTY_P));

endmodule : fifo_sync_1r1w_flex

// File: tb/tb_fifo_sync_1r1w_flex.sv
// ----------------------------------------------------------------------------
// tb_fifo_sync_1r1w_flex
// Two instances share one set of inputs: depth 12 (default) and depth 5.
// A selector picks which instance's outputs are compared against a queue-based
// reference model; the other instance is reset whenever the selection changes.
// ----------------------------------------------------------------------------
module tb_fifo_sync_1r1w_flex;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] data_in = '0;
    logic        valid = 1'b0;
    logic        yumi = 1'b0;
    int          sel = 0;

    logic        ready0, valid0, afull0, aempty0, err0;
    logic [31:0] data0;
    logic [3:0]  count0;
    logic        ready1, valid1, afull1, aempty1, err1;
    logic [31:0] data1;
    logic [2:0]  count1;

    logic        obs_ready, obs_valid, obs_afull, obs_aempty, obs_err;
    logic [31:0] obs_data;
    logic [3:0]  obs_count;

    int checks = 0;
    int failures = 0;

    // Reference model state.
    logic [31:0] exp_q[$];
    bit          m_err;
    int          m_depth, m_afull, m_aempty;

    always #5 clk = ~clk;

    fifo_sync_1r1w_flex #(
        .WIDTH_P (32), .DEPTH_P (12), .AFULL_P (10), .AEMPTY_P (2)
    ) dut12 (
        .clk_i (clk), .reset_n_i (reset_n), .flush_i (flush),
        .data_i (data_in), .valid_i (valid), .ready_o (ready0),
        .valid_o (valid0), .data_o (data0), .yumi_i (yumi),
        .count_o (count0), .almost_full_o (afull0),
        .almost_empty_o (aempty0), .err_o (err0)
    );

    fifo_sync_1r1w_flex #(
        .WIDTH_P (32), .DEPTH_P (5), .AFULL_P (3), .AEMPTY_P (2)
    ) dut5 (
        .clk_i (clk), .reset_n_i (reset_n), .flush_i (flush),
        .data_i (data_in), .valid_i (valid), .ready_o (ready1),
        .valid_o (valid1), .data_o (data1), .yumi_i (yumi),
        .count_o (count1), .almost_full_o (afull1),
        .almost_empty_o (aempty1), .err_o (err1)
    );

    always_comb begin
        obs_ready  = (sel == 1) ? ready1  : ready0;
        obs_valid  = (sel == 1) ? valid1  : valid0;
        obs_data   = (sel == 1) ? data1   : data0;
        obs_count  = (sel == 1) ? {1'b0, count1} : count0;
        obs_afull  = (sel == 1) ? afull1  : afull0;
        obs_aempty = (sel == 1) ? aempty1 : aempty0;
        obs_err    = (sel == 1) ? err1    : err0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_model();
        int n;
        n = exp_q.size();
        check("valid_o", {31'b0, obs_valid}, {31'b0, n != 0});
        check("ready_o", {31'b0, obs_ready}, {31'b0, n < m_depth});
        check("count_o", {28'b0, obs_count}, n);
        check("almost_full_o", {31'b0, obs_afull}, {31'b0, n >= m_afull});
        check("almost_empty_o", {31'b0, obs_aempty}, {31'b0, n <= m_aempty});
        check("err_o", {31'b0, obs_err}, {31'b0, m_err});
        if (n != 0) check("data_o", obs_data, exp_q[0]);
    endtask

    // Inputs are already applied (at a falling edge); advance one clock,
    // update the model from the FIFO rules, then compare at the next falling edge.
    task automatic step();
        bit do_enq, do_deq;
        @(posedge clk);
        if (flush) begin
            exp_q.delete();
            m_err = 1'b0;
        end else begin
            do_enq = valid && (exp_q.size() < m_depth);
            do_deq = yumi && (exp_q.size() > 0);
            if (yumi && exp_q.size() == 0) m_err = 1'b1;
            if (do_deq) void'(exp_q.pop_front());
            if (do_enq) exp_q.push_back(data_in);
        end
        @(negedge clk);
        check_model();
    endtask

    task automatic drive(input bit v, input logic [31:0] d, input bit y, input bit f);
        valid   = v;
        data_in = d;
        yumi    = y;
        flush   = f;
        step();
    endtask

    task automatic idle();
        valid = 1'b0; yumi = 1'b0; flush = 1'b0; data_in = '0;
    endtask

    task automatic reset_select(input int s, input int depth, input int afull);
        idle();
        reset_n = 1'b0;
        sel = s;
        m_depth = depth; m_afull = afull; m_aempty = 2;
        exp_q.delete();
        m_err = 1'b0;
        repeat (2) @(negedge clk);
        check("reset ready_o", {31'b0, obs_ready}, 32'd1);
        check("reset valid_o", {31'b0, obs_valid}, 32'd0);
        check("reset count_o", {28'b0, obs_count}, 32'd0);
        check("reset almost_full_o", {31'b0, obs_afull}, 32'd0);
        check("reset almost_empty_o", {31'b0, obs_aempty}, 32'd1);
        check("reset err_o", {31'b0, obs_err}, 32'd0);
        reset_n = 1'b1;
    endtask

    task automatic random_run(input int cycles);
        int p_in;
        p_in = 50;
        for (int i = 0; i < cycles; i++) begin
            if (i % 60 == 0) p_in = $urandom_range(10, 90);
            valid   = ($urandom_range(0, 99) < p_in);
            data_in = $urandom;
            if (exp_q.size() > 0) yumi = ($urandom_range(0, 99) >= p_in);
            else                  yumi = ($urandom_range(0, 24) == 0);
            flush   = ($urandom_range(0, 79) == 0);
            step();
        end
        idle();
    endtask

    initial begin
        // ---------------- depth 12 instance ----------------
        reset_select(0, 12, 10);

        // Fill / drain
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 32'h100 + i, 1'b0, 1'b0);
            if (i == 8) check("afull below threshold", {31'b0, obs_afull}, 32'd0);
            if (i == 9) check("afull at 10", {31'b0, obs_afull}, 32'd1);
        end
        check("full ready_o", {31'b0, obs_ready}, 32'd0);
        check("full count_o", {28'b0, obs_count}, 32'd12);
        for (int i = 0; i < 12; i++) begin
            check("drain order", obs_data, 32'h100 + i);
            drive(1'b0, '0, 1'b1, 1'b0);
        end
        check("drained valid_o", {31'b0, obs_valid}, 32'd0);

        // Full with simultaneous valid and yumi: no enqueue that cycle
        for (int i = 0; i < 12; i++) drive(1'b1, 32'h200 + i, 1'b0, 1'b0);
        drive(1'b1, 32'hDEAD, 1'b1, 1'b0);
        check("full+yumi count_o", {28'b0, obs_count}, 32'd11);
        check("full+yumi head", obs_data, 32'h201);
        drive(1'b0, '0, 1'b0, 1'b1);

        // Bypass into a one-entry FIFO
        drive(1'b1, 32'hAA, 1'b0, 1'b0);
        check("bypass first head", obs_data, 32'hAA);
        drive(1'b1, 32'hBB, 1'b1, 1'b0);
        check("bypass data_o", obs_data, 32'hBB);
        check("bypass count_o", {28'b0, obs_count}, 32'd1);
        drive(1'b0, '0, 1'b1, 1'b0);

        // Error then flush with a dropped enqueue
        drive(1'b0, '0, 1'b1, 1'b0);
        check("underflow err_o", {31'b0, obs_err}, 32'd1);
        for (int i = 0; i < 4; i++) drive(1'b1, 32'h300 + i, 1'b0, 1'b0);
        check("err sticky", {31'b0, obs_err}, 32'd1);
        drive(1'b1, 32'h55, 1'b0, 1'b1);
        check("flush count_o", {28'b0, obs_count}, 32'd0);
        check("flush valid_o", {31'b0, obs_valid}, 32'd0);
        check("flush err_o", {31'b0, obs_err}, 32'd0);
        check("flush ready_o", {31'b0, obs_ready}, 32'd1);

        // Asynchronous reset between edges with 7 entries stored
        for (int i = 0; i < 7; i++) drive(1'b1, 32'h400 + i, 1'b0, 1'b0);
        idle();
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("async count_o", {28'b0, obs_count}, 32'd0);
        check("async valid_o", {31'b0, obs_valid}, 32'd0);
        check("async ready_o", {31'b0, obs_ready}, 32'd1);
        check("async almost_empty_o", {31'b0, obs_aempty}, 32'd1);
        exp_q.delete();
        m_err = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0);

        random_run(800);

        // ---------------- depth 5 instance ----------------
        reset_select(1, 5, 3);
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 3; i++) drive(1'b1, 32'h500 + 3 * r + i, 1'b0, 1'b0);
            for (int i = 0; i < 3; i++) begin
                check("wrap order", obs_data, 32'h500 + 3 * r + i);
                drive(1'b0, '0, 1'b1, 1'b0);
            end
            check("wrap count_o", {28'b0, obs_count}, 32'd0);
        end
        random_run(800);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fifo_sync_1r1w_flex
